piso_serializer: RTL
====================

# piso_serializer

Parallel-in serial-out serializer that sits directly upstream of the SIPO shift register and drives its serial input `a_in`. It accepts WIDTH-bit words through a valid/ready handshake and holds one word in a buffer while the previous word shifts out. It emits one bit per clock, with frame markers so the downstream SIPO side can align words. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 4: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts the MSB out first; 0 shifts the LSB out first.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous reset, active-high.
- `data_in`  in  WIDTH  parallel word to serialize.
- `load_valid`  in  1  `data_in` is valid this cycle.
- `load_ready`  out  1  a word is accepted when `load_valid & load_ready` is true at a rising edge.
- `a_out`  out  1  serial data; connects to the SIPO `a_in`.
- `out_valid`  out  1  high while `a_out` carries a word bit.
- `frame_start`  out  1  one-cycle pulse coincident with bit 0 of each word.
- `word_done`  out  1  one-cycle pulse coincident with the last bit of each word.

## Operation
- **Storage**
  - Holding register `hold[WIDTH-1:0]` with flag `hold_full`.
  - Shift register `shreg[WIDTH-1:0]`.
  - Bit counter `cnt`, width `$clog2(WIDTH)`.
  - State register with states IDLE and SHIFT.
- **Ready and accept**
  - `load_ready = ~hold_full & ~reset` (combinational).
  - On accept: `hold <= data_in` and `hold_full <= 1`.
- **Transfer condition** `xfer = hold_full & (state==IDLE | last)`, where `last = (state==SHIFT & cnt==WIDTH-1)`.
- **On xfer**
  - `shreg <= hold`, `cnt <= 0`, `hold_full <= 0`, `state <= SHIFT`.
  - An accept cannot happen in the same cycle, because `load_ready` is 0 while `hold_full` is 1.
- **SHIFT, not last**
  - `cnt <= cnt+1`.
  - `shreg` shifts left (`MSB_FIRST=1`) or right (`MSB_FIRST=0`), with 0 filled in.
- **SHIFT, last, no xfer** → `state <= IDLE`.
- **Outputs**
  - `a_out` = `shreg[WIDTH-1]` (MSB_FIRST) or `shreg[0]` when in SHIFT; otherwise 0.
  - `out_valid = (state==SHIFT)`.
  - `frame_start = out_valid & cnt==0`.
  - `word_done = last`.
- **State transitions:** IDLE→SHIFT on xfer; SHIFT→SHIFT on `~last`, or on `last & hold_full`; SHIFT→IDLE on `last & ~hold_full`.
- **Reset**
  - Sampled at the rising edge.
  - Clears `state` to IDLE and clears `hold_full`, `cnt` and `shreg`.
  - Any word in flight or held is discarded, with no partial completion.
  - While `reset` is high, no accept occurs.

## Timing
- **Reset values:** `a_out`=0, `out_valid`=0, `frame_start`=0, `word_done`=0. `load_ready` is 0 while `reset`=1 and 1 in the first cycle after `reset` is released.
- **Latency from idle**
  - Word accepted at edge E0.
  - xfer occurs at E1.
  - Bit 0 appears on `a_out` in the cycle after E1.
  - The last bit appears WIDTH-1 cycles later.
- **Streaming**
  - `hold` refills at any point during the current word.
  - The next word's bit 0 follows the current word's last bit in the next cycle, with no gap.
  - Sustained throughput is one word per WIDTH cycles.
- **Backpressure:** `load_ready` stays low from acceptance until the held word transfers into `shreg`. A source that holds `load_valid` high across stalls keeps `data_in` stable.
- **Simultaneous events**
  - `last` and `hold_full` in the same cycle: reload, and no IDLE cycle occurs.
  - `reset` together with `load_valid`: reset wins and the word is dropped.
- All outputs are registered or derived from registers, except the `load_ready` gating by `reset`.

## Test plan
- **Single word (WIDTH=4, MSB_FIRST=1)**
  - Stimulus: `data_in`=4'b1011 accepted at E0.
  - Required response: `a_out`=1,0,1,1 in the four cycles after E1.
  - `out_valid` is high for exactly 4 cycles.
  - `frame_start` fires with the first 1 and `word_done` fires with the final 1.
  - Afterwards `a_out`=0 and the block is in IDLE.
- **Back-to-back streaming:** with 4'b1100, 4'b0011 and 4'b1010 offered continuously, `a_out`=110000111010 with `out_valid` held high for 12 consecutive cycles and 3 `frame_start` pulses spaced 4 cycles apart.
- **Backpressure:** with `load_valid` held high and the hold buffer full, `load_ready`=0 until the transfer edge. There is exactly one accept per word and no word is duplicated or lost.
- **LSB first:** with `MSB_FIRST=0`, 4'b1011 serializes as `a_out`=1,1,0,1.
- **Reset mid-word:** assert `reset` for one cycle after 2 bits of 4'b1111 have shifted out, with a second word held in `hold`. On the next cycle `out_valid`=0 and `a_out`=0, and neither word resumes. A fresh word afterwards meets the single-word latency.
- **End-to-end with the SIPO downstream:** after each `word_done`, the SIPO parallel output equals the word that was sent, for words 4'b0000 and 4'b1111.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with one-word holding buffer and frame markers.
// Streams back-to-back words with no idle gap between them.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             a_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             word_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             last, xfer, accept;

  assign last       = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign xfer       = hold_full && ((state == IDLE) || last);
  assign load_ready = ~hold_full & ~reset;
  assign accept     = load_valid & load_ready;

  // Outputs decode directly from the shift state
  assign out_valid   = (state == SHIFT);
  assign frame_start = out_valid && (cnt == '0);
  assign word_done   = last;
  assign a_out       = out_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

  // Next-state and datapath update
  always_comb begin
    state_n     = state;
    hold_n      = hold;
    hold_full_n = hold_full;
    shreg_n     = shreg;
    cnt_n       = cnt;

    if (xfer) begin
      shreg_n     = hold;
      cnt_n       = '0;
      hold_full_n = 1'b0;
      state_n     = SHIFT;
    end else if (state == SHIFT) begin
      if (last) begin
        state_n = IDLE;
      end else begin
        cnt_n   = cnt + CW'(1);
        shreg_n = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      end
    end

    // Accept is exclusive with xfer since load_ready requires an empty buffer
    if (accept) begin
      hold_n      = data_in;
      hold_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
    end
  end

endmodule
